// File: rtl/enemy_track_if.sv
// enemy_track bus: game-step strobe, raw enemy observations in,
// per-enemy track registers out.
interface enemy_track_if #(
  parameter int NUM_ENEMIES = 3,
  parameter int VEL_W       = 6
);
  logic                           step;
  logic signed [7:0]              enemy_x_p [NUM_ENEMIES];
  logic signed [7:0]              enemy_y_p [NUM_ENEMIES];
  logic        [NUM_ENEMIES-1:0]  enemy_cloaked;
  logic        [NUM_ENEMIES-1:0]  enemy_destroyed;
  logic signed [7:0]              pred_x [NUM_ENEMIES];
  logic signed [7:0]              pred_y [NUM_ENEMIES];
  logic signed [VEL_W-1:0]        vel_x [NUM_ENEMIES];
  logic signed [VEL_W-1:0]        vel_y [NUM_ENEMIES];
  logic        [3:0]              coast_age [NUM_ENEMIES];
  logic        [2:0]              track_state [NUM_ENEMIES];
  logic        [NUM_ENEMIES-1:0]  track_valid;
  logic signed [7:0]              lead_x [NUM_ENEMIES];
  logic signed [7:0]              lead_y [NUM_ENEMIES];

  modport master (
    output step, enemy_x_p, enemy_y_p, enemy_cloaked, enemy_destroyed,
    input  pred_x, pred_y, vel_x, vel_y, coast_age, track_state,
    input  track_valid, lead_x, lead_y
  );

  modport slave (
    input  step, enemy_x_p, enemy_y_p, enemy_cloaked, enemy_destroyed,
    output pred_x, pred_y, vel_x, vel_y, coast_age, track_state,
    output track_valid, lead_x, lead_y
  );
endinterface

// File: rtl/enemy_track.sv
// enemy_track: per-enemy position/velocity/coast tracker for strategy logic.
// ENEMY_TRACK_LEAD_EN enables velocity-led aim points on lead_x/lead_y.
module enemy_track #(
  parameter int NUM_ENEMIES = 3,
  parameter int VEL_W       = 6,
  parameter int BOUND       = 64,
  parameter int MAX_COAST   = 4,
  parameter int LEAD_STEPS  = 2
) (
  input  logic         clk,
  input  logic         reset,
  enemy_track_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACQ   = 3'd1,
    TRACK = 3'd2,
    COAST = 3'd3,
    LOST  = 3'd4,
    DEAD  = 3'd5
  } state_e;

  localparam logic signed [8:0]  VMAX    = 9'(2**(VEL_W-1)-1);
  localparam logic signed [8:0]  VMIN    = -VMAX - 9'sd1;
  localparam logic signed [8:0]  BMAX    = 9'(BOUND);
  localparam logic signed [8:0]  BMIN    = -BMAX;
  localparam logic signed [11:0] LMAX    = 12'(BOUND);
  localparam logic signed [11:0] LMIN    = -LMAX;
  localparam logic        [3:0]  AGE_MAX = 4'(MAX_COAST);
`ifdef ENEMY_TRACK_LEAD_EN
  localparam logic signed [11:0] LK      = 12'(LEAD_STEPS);
`else
  localparam logic signed [11:0] LK      = 12'(LEAD_STEPS * 0);
`endif

  function automatic logic signed [VEL_W-1:0] sat_v(
    input logic signed [8:0] d
  );
    if (d > VMAX) return VMAX[VEL_W-1:0];
    if (d < VMIN) return VMIN[VEL_W-1:0];
    return d[VEL_W-1:0];
  endfunction

  function automatic logic signed [7:0] clamp9(
    input logic signed [8:0] s
  );
    if (s > BMAX) return BMAX[7:0];
    if (s < BMIN) return BMIN[7:0];
    return s[7:0];
  endfunction

  function automatic logic signed [7:0] clamp12(
    input logic signed [11:0] s
  );
    if (s > LMAX) return LMAX[7:0];
    if (s < LMIN) return LMIN[7:0];
    return s[7:0];
  endfunction

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_e
    state_e                  st_q, st_d;
    logic signed [7:0]       px_q, px_d, py_q, py_d;
    logic signed [7:0]       lx_q, lx_d, ly_q, ly_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic        [3:0]       age_q, age_d;
    logic signed [8:0]       dx, dy, sx, sy;
    logic signed [11:0]      ax, ay;
    logic                    cl, de, vis;
    logic signed [7:0]       nx, ny;

    assign nx  = bus.enemy_x_p[g];
    assign ny  = bus.enemy_y_p[g];
    assign cl  = bus.enemy_cloaked[g];
    assign de  = bus.enemy_destroyed[g];
    assign vis = !cl && !de;

    // 9-bit signed so neither the difference nor the sum can wrap
    assign dx = {nx[7], nx} - {px_q[7], px_q};
    assign dy = {ny[7], ny} - {py_q[7], py_q};
    assign sx = {px_q[7], px_q} + {{(9-VEL_W){vx_q[VEL_W-1]}}, vx_q};
    assign sy = {py_q[7], py_q} + {{(9-VEL_W){vy_q[VEL_W-1]}}, vy_q};

    always_comb begin
      st_d  = st_q;
      px_d  = px_q;
      py_d  = py_q;
      vx_d  = vx_q;
      vy_d  = vy_q;
      age_d = age_q;
      if (de) begin
        st_d  = DEAD;
        vx_d  = '0;
        vy_d  = '0;
        age_d = '0;
      end else begin
        unique case (st_q)
          IDLE: if (vis) begin
            st_d = ACQ;
            px_d = nx;
            py_d = ny;
            vx_d = '0;
            vy_d = '0;
          end
          ACQ: if (vis) begin
            st_d = TRACK;
            vx_d = sat_v(dx);
            vy_d = sat_v(dy);
            px_d = nx;
            py_d = ny;
          end else begin
            st_d  = COAST;
            age_d = 4'd1;
          end
          TRACK: if (vis) begin
            vx_d = sat_v(dx);
            vy_d = sat_v(dy);
            px_d = nx;
            py_d = ny;
          end else begin
            st_d  = COAST;
            age_d = 4'd1;
            px_d  = clamp9(sx);
            py_d  = clamp9(sy);
          end
          COAST, LOST: if (vis) begin
            st_d  = ACQ;
            px_d  = nx;
            py_d  = ny;
            vx_d  = '0;
            vy_d  = '0;
            age_d = '0;
          end else if (st_q == COAST) begin
            age_d = age_q + 4'd1;
            px_d  = clamp9(sx);
            py_d  = clamp9(sy);
            if (age_q + 4'd1 == AGE_MAX) st_d = LOST;
          end else begin
            vx_d  = '0;
            vy_d  = '0;
            age_d = AGE_MAX;
          end
          DEAD: ;
          default: st_d = IDLE;
        endcase
      end
    end

    // lead is only led ahead for moving tracks; otherwise it mirrors pred
    always_comb begin
      ax = {{4{px_d[7]}}, px_d}
         + LK * {{(12-VEL_W){vx_d[VEL_W-1]}}, vx_d};
      ay = {{4{py_d[7]}}, py_d}
         + LK * {{(12-VEL_W){vy_d[VEL_W-1]}}, vy_d};
      lx_d = px_d;
      ly_d = py_d;
      if (LK != 12'sd0 && (st_d == TRACK || st_d == COAST)) begin
        lx_d = clamp12(ax);
        ly_d = clamp12(ay);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        px_q  <= '0;
        py_q  <= '0;
        vx_q  <= '0;
        vy_q  <= '0;
        age_q <= '0;
        lx_q  <= '0;
        ly_q  <= '0;
      end else if (bus.step) begin
        st_q  <= st_d;
        px_q  <= px_d;
        py_q  <= py_d;
        vx_q  <= vx_d;
        vy_q  <= vy_d;
        age_q <= age_d;
        lx_q  <= lx_d;
        ly_q  <= ly_d;
      end
    end

    assign bus.pred_x[g]      = px_q;
    assign bus.pred_y[g]      = py_q;
    assign bus.vel_x[g]       = vx_q;
    assign bus.vel_y[g]       = vy_q;
    assign bus.coast_age[g]   = age_q;
    assign bus.track_state[g] = st_q;
    assign bus.lead_x[g]      = lx_q;
    assign bus.lead_y[g]      = ly_q;
    assign bus.track_valid[g] = (st_q == ACQ) || (st_q == TRACK)
                             || (st_q == COAST);
  end
endmodule

// File: doc/enemy_track.md
Name: enemy_track

Overview:
- Per-enemy tracking stage. Sits directly upstream of the per-ship strategy logic.
- Converts raw enemy positions, cloak flags and destroyed flags into a registered per-enemy track:
  - last-known / dead-reckoned position,
  - saturated velocity estimate,
  - coast age,
  - track state.
- Purpose: strategy logic aims and evades against cloaked enemies without keeping its own history registers.

Parameters:
- NUM_ENEMIES, 3, number of enemy ships tracked (index range matches ship range).
- VEL_W, 6, signed velocity width; estimates saturate to [-2^(VEL_W-1), 2^(VEL_W-1)-1].
- BOUND, 64, arena clamp; predicted coordinates limited to [-BOUND, +BOUND].
- MAX_COAST, 4, cloaked cycles dead-reckoned before the track is declared LOST (1..15).
- LEAD_STEPS, 2, velocity multiples added for lead outputs (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- step  in  1  game-step strobe; updates occur only on cycles with step=1
- enemy_x_p[NUM_ENEMIES]  in  8 signed  enemy x; stale while cloaked
- enemy_y_p[NUM_ENEMIES]  in  8 signed  enemy y; stale while cloaked
- enemy_cloaked  in  NUM_ENEMIES  per-enemy cloak flag
- enemy_destroyed  in  NUM_ENEMIES  per-enemy destroyed flag
- pred_x[NUM_ENEMIES]  out  8 signed  tracked/predicted x
- pred_y[NUM_ENEMIES]  out  8 signed  tracked/predicted y
- vel_x[NUM_ENEMIES]  out  VEL_W signed  velocity estimate x
- vel_y[NUM_ENEMIES]  out  VEL_W signed  velocity estimate y
- coast_age[NUM_ENEMIES]  out  4  consecutive cloaked steps since last sighting
- track_state[NUM_ENEMIES]  out  3  0 IDLE, 1 ACQ, 2 TRACK, 3 COAST, 4 LOST, 5 DEAD
- track_valid  out  NUM_ENEMIES  1 when state is ACQ, TRACK or COAST
- lead_x[NUM_ENEMIES]  out  8 signed  aim-point x
- lead_y[NUM_ENEMIES]  out  8 signed  aim-point y

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous, active-high, port named reset.
  - Reset sets, for every enemy: state IDLE; pred, vel, lead, coast_age all 0; track_valid 0.
  - Reset mid-operation discards all history.
- Timing:
  - All outputs are registered. Latency is 1 cycle: outputs reflect inputs sampled at the previous step=1 edge.
  - step=0: all state and outputs hold.
- Per enemy, evaluated on each step=1 edge. "visible" = !cloaked && !destroyed. Priority order:
  - destroyed=1 (any state) -> DEAD. pred frozen, vel=0, age=0. DEAD is absorbing until reset, even if destroyed later deasserts.
  - IDLE:
    - visible -> ACQ; pred=input position, vel=0.
    - cloaked -> stay IDLE.
  - ACQ:
    - visible -> TRACK; vel=sat(new-pred); pred=new.
    - cloaked -> COAST; age=1; pred+=vel (vel is 0, so pred holds).
  - TRACK:
    - visible -> TRACK; vel=sat(new-pred); pred=new.
    - cloaked -> COAST; age=1; pred=clamp(pred+vel).
  - COAST:
    - visible -> ACQ; pred=new; vel=0; age=0.
    - cloaked -> age+=1; pred=clamp(pred+vel). If the new age equals MAX_COAST -> LOST (pred is still advanced on that step).
  - LOST:
    - visible -> ACQ; pred=new; vel=0; age=0.
    - cloaked -> hold pred; vel=0; age saturates at MAX_COAST.
- Arithmetic:
  - Differences and sums are computed at 9-bit signed, then saturated/clamped. No wrap-around is permitted.
  - sat(): clamps to the VEL_W range.
  - clamp(): clamps to [-BOUND, BOUND].
  - Velocity is sign-extended before adding to pred.
- Enemies are fully independent. Simultaneous events on different enemies are handled in the same cycle.

Optional Feature:
- Macro: ENEMY_TRACK_LEAD_EN.
- Defined:
  - lead = clamp(pred_next + LEAD_STEPS*vel_next), registered with pred, same latency.
  - The product is computed at 12-bit signed before clamping.
  - In ACQ, LOST and DEAD, lead equals pred.
- Undefined: lead_x/lead_y are registered copies of pred_x/pred_y. Ports remain present.

Test Plan:
- Acquire then track (enemy 0): reset; step; enemy0 visible at (10,-5) -> next cycle state=1, pred=(10,-5), vel=(0,0), track_valid[0]=1. Then (13,-7) -> state=2, vel=(3,-2), pred=(13,-7).
- Coast then lose (MAX_COAST=4), continuing the track above:
  - cloak 3 steps -> pred (16,-9), (19,-11), (22,-13); age 1, 2, 3; state=3.
  - 4th cloaked step -> pred (25,-15), age 4, state=4, track_valid=0.
  - 5th cloaked step -> pred unchanged, vel=(0,0).
- Saturation and clamp:
  - visible x=120 then x=-120 -> vel_x=-32.
  - track x=50 then 57 (vel 7), then cloak -> pred_x 64, then stays 64 (clamped).
- Destroy and reset: destroyed[1] asserted during COAST -> state=5 next cycle, pred frozen; later visible input ignored; reset -> state=0, all outputs 0.
- Step gating and independence: step=0 with changing inputs -> all outputs hold. Enemy 0 visible and enemy 2 cloaked in the same step -> each follows its own transition.
- Lead (ENEMY_TRACK_LEAD_EN, LEAD_STEPS=2): TRACK at pred=(13,-7), vel=(3,-2) -> lead=(19,-11). Without the macro -> lead=(13,-7).
